// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the load/store unit: access size
// encodings, LSU FSM state encodings, the latched request record and the
// small combinational helpers for alignment, byte enables and store lanes.
package riscv_pkg;

    // Access size encodings; identical to the sign_trim_ctrl trim encoding.
    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    // LSU controller FSM state encodings.
    localparam logic [1:0] LSU_IDLE = 2'b00;
    localparam logic [1:0] LSU_ADDR = 2'b01;
    localparam logic [1:0] LSU_WAIT = 2'b10;
    localparam logic [1:0] LSU_RESP = 2'b11;

    // Request fields still needed after the bus request has been issued.
    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       sext;
        logic [1:0] addr_lo;
        logic [4:0] rd;
    } lsu_req_t;

    // Half accesses need an even address; words (and size 11) need a
    // word-aligned address; bytes can never be misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            default:   return (addr_lo != 2'b00);
        endcase
    endfunction

    // Byte enables for an access within the addressed word.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 4'b0001 << addr_lo;
            SIZE_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    // Replicate right-aligned store data across every lane so the enabled
    // bytes always see the correct value regardless of the address offset.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SIZE_BYTE: return {4{wdata[7:0]}};
            SIZE_HALF: return {2{wdata[15:0]}};
            default:   return wdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Execute-side request, writeback-side response and data-memory bus signals
// of the load/store unit, bundled so the controller and its environment
// connect through one port. The slave view belongs to the controller.
interface lsu_ctrl_if;

    // Execute-stage request
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_sign_extend_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  req_rd_i;

    // Writeback response
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic [4:0]  rsp_rd_o;
    logic        rsp_err_o;

    // Data-memory bus
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_sign_extend_i,
        input  req_addr_i, req_wdata_i, req_rd_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_rd_o, rsp_err_o,
        input  rsp_ready_i,
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_sign_extend_i,
        output req_addr_i, req_wdata_i, req_rd_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_rd_o, rsp_err_o,
        output rsp_ready_i,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
    );

endinterface

// File: rtl/sign_trim_ctrl.sv
// Trims a right-aligned load word to byte, half or word width and either
// sign-extends or zero-extends the kept part back to 32 bits.
module sign_trim_ctrl
    import riscv_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  trim_i,
    input  logic        sign_extend_i,
    output logic [31:0] data_o
);

    // Select the kept width and fill the upper bits with sign or zero.
    always_comb begin
        data_o = data_i;
        case (trim_i)
            SIZE_BYTE: begin
                if (sign_extend_i) begin
                    data_o = {{24{data_i[7]}}, data_i[7:0]};
                end else begin
                    data_o = {24'h00_0000, data_i[7:0]};
                end
            end
            SIZE_HALF: begin
                if (sign_extend_i) begin
                    data_o = {{16{data_i[15]}}, data_i[15:0]};
                end else begin
                    data_o = {16'h0000, data_i[15:0]};
                end
            end
            default: begin
                data_o = data_i;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one access at a time from execute,
// rejects misaligned accesses without touching the bus, issues a word-aligned
// request with byte enables, waits for the response under a timeout and
// returns aligned and extended load data to writeback.
module lsu_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    lsu_ctrl_if.slave bus
);

    // Value of the wait counter in the last WAIT cycle before a timeout.
    localparam logic [7:0] TIMEOUT_LAST_C = 8'(TIMEOUT - 32'd1);

    logic [1:0]  state_r;
    logic [1:0]  state_s;
    lsu_req_t    req_r;
    logic [7:0]  cnt_r;

    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [3:0]  mem_be_r;
    logic        mem_we_r;

    logic [31:0] rsp_rdata_r;
    logic [4:0]  rsp_rd_r;
    logic        rsp_err_r;

    logic        accept_s;
    logic        misaligned_s;
    logic        timeout_s;
    logic [4:0]  rsp_tag_s;
    logic [31:0] shifted_s;
    logic [31:0] trimmed_s;

    assign accept_s     = (state_r == LSU_IDLE) && bus.req_valid_i;
    assign misaligned_s = is_misaligned(bus.req_size_i, bus.req_addr_i[1:0]);
    assign timeout_s    = (cnt_r == TIMEOUT_LAST_C);
    // Stores never return a destination tag.
    assign rsp_tag_s    = req_r.we ? 5'd0 : req_r.rd;

    // Move the addressed byte/half down to bit 0 before extension.
    assign shifted_s = bus.mem_rdata_i >> {req_r.addr_lo, 3'b000};

    sign_trim_ctrl u_sign_trim (
        .data_i        (shifted_s),
        .trim_i        (req_r.size),
        .sign_extend_i (req_r.sext),
        .data_o        (trimmed_s)
    );

    // Next-state decode of the access sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            LSU_IDLE: begin
                if (accept_s) begin
                    state_s = misaligned_s ? LSU_RESP : LSU_ADDR;
                end else begin
                    state_s = LSU_IDLE;
                end
            end
            LSU_ADDR: begin
                if (bus.mem_gnt_i) begin
                    state_s = LSU_WAIT;
                end else begin
                    state_s = LSU_ADDR;
                end
            end
            LSU_WAIT: begin
                // A response in the timeout cycle takes priority.
                if (bus.mem_rvalid_i) begin
                    state_s = LSU_RESP;
                end else if (timeout_s) begin
                    state_s = LSU_RESP;
                end else begin
                    state_s = LSU_WAIT;
                end
            end
            LSU_RESP: begin
                if (bus.rsp_ready_i) begin
                    state_s = LSU_IDLE;
                end else begin
                    state_s = LSU_RESP;
                end
            end
            default: begin
                state_s = LSU_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= LSU_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request latch, bus request fields, wait counter and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_r       <= '0;
            cnt_r       <= 8'd0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            mem_be_r    <= 4'b0000;
            mem_we_r    <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_rd_r    <= 5'd0;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                LSU_IDLE: begin
                    if (accept_s) begin
                        req_r.we      <= bus.req_we_i;
                        req_r.size    <= bus.req_size_i;
                        req_r.sext    <= bus.req_sign_extend_i;
                        req_r.addr_lo <= bus.req_addr_i[1:0];
                        req_r.rd      <= bus.req_rd_i;
                        mem_addr_r    <= {bus.req_addr_i[31:2], 2'b00};
                        mem_we_r      <= bus.req_we_i;
                        mem_be_r      <= byte_enable(bus.req_size_i, bus.req_addr_i[1:0]);
                        mem_wdata_r   <= store_lanes(bus.req_size_i, bus.req_wdata_i);
                        if (misaligned_s) begin
                            rsp_err_r   <= 1'b1;
                            rsp_rdata_r <= 32'd0;
                            rsp_rd_r    <= bus.req_we_i ? 5'd0 : bus.req_rd_i;
                        end
                    end
                end
                LSU_ADDR: begin
                    if (bus.mem_gnt_i) begin
                        cnt_r <= 8'd0;
                    end
                end
                LSU_WAIT: begin
                    if (bus.mem_rvalid_i) begin
                        rsp_err_r   <= bus.mem_err_i;
                        rsp_rd_r    <= rsp_tag_s;
                        rsp_rdata_r <= (req_r.we || bus.mem_err_i) ? 32'd0 : trimmed_s;
                    end else if (timeout_s) begin
                        rsp_err_r   <= 1'b1;
                        rsp_rd_r    <= rsp_tag_s;
                        rsp_rdata_r <= 32'd0;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                LSU_RESP: begin
                    // Response outputs read as zero outside RESP.
                    if (bus.rsp_ready_i) begin
                        rsp_err_r   <= 1'b0;
                        rsp_rd_r    <= 5'd0;
                        rsp_rdata_r <= 32'd0;
                    end
                end
                default: begin
                    cnt_r <= 8'd0;
                end
            endcase
        end
    end

    assign bus.req_ready_o = (state_r == LSU_IDLE);
    assign bus.mem_req_o   = (state_r == LSU_ADDR);
    assign bus.rsp_valid_o = (state_r == LSU_RESP);
    assign bus.mem_addr_o  = mem_addr_r;
    assign bus.mem_we_o    = mem_we_r;
    assign bus.mem_be_o    = mem_be_r;
    assign bus.mem_wdata_o = mem_wdata_r;
    assign bus.rsp_rdata_o = rsp_rdata_r;
    assign bus.rsp_rd_o    = rsp_rd_r;
    assign bus.rsp_err_o   = rsp_err_r;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed testbench for lsu_ctrl: a vector table of single accesses with
// hand-computed bus fields and results, plus sequences for timeout, response
// in the timeout cycle, late response in IDLE and reset during WAIT.
module tb_lsu_ctrl;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    lsu_ctrl_if bus_if ();

    lsu_ctrl #(.TIMEOUT(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic        mis;
        logic        merr;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        logic [4:0]  e_rd;
        logic        e_err;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus_if.req_valid_i       = 1'b0;
        bus_if.req_we_i          = 1'b0;
        bus_if.req_size_i        = 2'b00;
        bus_if.req_sign_extend_i = 1'b0;
        bus_if.req_addr_i        = 32'd0;
        bus_if.req_wdata_i       = 32'd0;
        bus_if.req_rd_i          = 5'd0;
        bus_if.rsp_ready_i       = 1'b0;
        bus_if.mem_gnt_i         = 1'b0;
        bus_if.mem_rvalid_i      = 1'b0;
        bus_if.mem_rdata_i       = 32'd0;
        bus_if.mem_err_i         = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".req_ready"}, 32'(bus_if.req_ready_o), 32'd1);
        chk({tag, ".mem_req"},   32'(bus_if.mem_req_o),   32'd0);
        chk({tag, ".mem_we"},    32'(bus_if.mem_we_o),    32'd0);
        chk({tag, ".mem_be"},    32'(bus_if.mem_be_o),    32'd0);
        chk({tag, ".mem_addr"},  bus_if.mem_addr_o,       32'd0);
        chk({tag, ".mem_wdata"}, bus_if.mem_wdata_o,      32'd0);
        chk({tag, ".rsp_valid"}, 32'(bus_if.rsp_valid_o), 32'd0);
        chk({tag, ".rsp_rdata"}, bus_if.rsp_rdata_o,      32'd0);
        chk({tag, ".rsp_rd"},    32'(bus_if.rsp_rd_o),    32'd0);
        chk({tag, ".rsp_err"},   32'(bus_if.rsp_err_o),   32'd0);
    endtask

    // Present a request in the current cycle; it is accepted at the next edge.
    task automatic issue(input logic we, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        @(negedge clk);
        bus_if.req_valid_i       = 1'b1;
        bus_if.req_we_i          = we;
        bus_if.req_size_i        = size;
        bus_if.req_sign_extend_i = sext;
        bus_if.req_addr_i        = addr;
        bus_if.req_wdata_i       = wdata;
        bus_if.req_rd_i          = rd;
        @(negedge clk);
        bus_if.req_valid_i = 1'b0;
    endtask

    // Complete the response handshake and confirm the return to IDLE.
    task automatic finish_rsp(input string tag);
        bus_if.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus_if.rsp_ready_i = 1'b0;
        chk({tag, ".rsp_valid_after"}, 32'(bus_if.rsp_valid_o), 32'd0);
        chk({tag, ".req_ready_after"}, 32'(bus_if.req_ready_o), 32'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        chk({tag, ".req_ready"}, 32'(bus_if.req_ready_o), 32'd1);
        issue(v.we, v.size, v.sext, v.addr, v.wdata, v.rd);
        // Now in cycle 1 after acceptance.
        if (v.mis) begin
            chk({tag, ".mis_valid"}, 32'(bus_if.rsp_valid_o), 32'd1);
            chk({tag, ".mis_memreq"}, 32'(bus_if.mem_req_o), 32'd0);
            for (int c = 0; c < 3; c++) begin
                chk({tag, ".hold_valid"}, 32'(bus_if.rsp_valid_o), 32'd1);
                chk({tag, ".hold_err"},   32'(bus_if.rsp_err_o),   32'(v.e_err));
                chk({tag, ".hold_rdata"}, bus_if.rsp_rdata_o,      v.e_rdata);
                chk({tag, ".hold_rd"},    32'(bus_if.rsp_rd_o),    32'(v.e_rd));
                chk({tag, ".hold_memreq"}, 32'(bus_if.mem_req_o),  32'd0);
                chk({tag, ".hold_ready"}, 32'(bus_if.req_ready_o), 32'd0);
                @(negedge clk);
            end
            finish_rsp(tag);
        end else begin
            chk({tag, ".mem_req"},   32'(bus_if.mem_req_o), 32'd1);
            chk({tag, ".mem_addr"},  bus_if.mem_addr_o,     v.e_addr);
            chk({tag, ".mem_be"},    32'(bus_if.mem_be_o),  32'(v.e_be));
            chk({tag, ".mem_wdata"}, bus_if.mem_wdata_o,    v.e_wdata);
            chk({tag, ".mem_we"},    32'(bus_if.mem_we_o),  32'(v.we));
            chk({tag, ".req_ready"}, 32'(bus_if.req_ready_o), 32'd0);
            bus_if.mem_gnt_i = 1'b1;
            @(negedge clk);
            bus_if.mem_gnt_i = 1'b0;
            chk({tag, ".wait_memreq"}, 32'(bus_if.mem_req_o),   32'd0);
            chk({tag, ".wait_valid"},  32'(bus_if.rsp_valid_o), 32'd0);
            bus_if.mem_rvalid_i = 1'b1;
            bus_if.mem_rdata_i  = v.rdata;
            bus_if.mem_err_i    = v.merr;
            @(negedge clk);
            bus_if.mem_rvalid_i = 1'b0;
            bus_if.mem_err_i    = 1'b0;
            bus_if.mem_rdata_i  = 32'hA5A5_5A5A;
            chk({tag, ".rsp_valid"}, 32'(bus_if.rsp_valid_o), 32'd1);
            chk({tag, ".rsp_rdata"}, bus_if.rsp_rdata_o,      v.e_rdata);
            chk({tag, ".rsp_rd"},    32'(bus_if.rsp_rd_o),    32'(v.e_rd));
            chk({tag, ".rsp_err"},   32'(bus_if.rsp_err_o),   32'(v.e_err));
            finish_rsp(tag);
        end
    endtask

    initial begin
        // we, size, sext, mis, merr, rd, addr, wdata, rdata,
        // e_addr, e_be, e_wdata, e_rdata, e_rd, e_err
        vecs[0]  = '{1'b0, SIZE_BYTE, 1'b1, 1'b0, 1'b0, 5'd5,  32'h0000_0103, 32'h0000_0000, 32'h80FF_1234,
                     32'h0000_0100, 4'b1000, 32'h0000_0000, 32'hFFFF_FF80, 5'd5,  1'b0};
        vecs[1]  = '{1'b0, SIZE_HALF, 1'b0, 1'b0, 1'b0, 5'd7,  32'h0000_0102, 32'h0000_0000, 32'h8001_0000,
                     32'h0000_0100, 4'b1100, 32'h0000_0000, 32'h0000_8001, 5'd7,  1'b0};
        vecs[2]  = '{1'b0, SIZE_HALF, 1'b1, 1'b0, 1'b0, 5'd8,  32'h0000_0102, 32'h0000_0000, 32'h8001_0000,
                     32'h0000_0100, 4'b1100, 32'h0000_0000, 32'hFFFF_8001, 5'd8,  1'b0};
        vecs[3]  = '{1'b1, SIZE_BYTE, 1'b0, 1'b0, 1'b0, 5'd9,  32'h0000_0201, 32'h0000_00AB, 32'hDEAD_BEEF,
                     32'h0000_0200, 4'b0010, 32'hABAB_ABAB, 32'h0000_0000, 5'd0,  1'b0};
        vecs[4]  = '{1'b0, SIZE_WORD, 1'b0, 1'b0, 1'b0, 5'd3,  32'h0000_0000, 32'h0000_0000, 32'h1234_5678,
                     32'h0000_0000, 4'b1111, 32'h0000_0000, 32'h1234_5678, 5'd3,  1'b0};
        vecs[5]  = '{1'b1, SIZE_HALF, 1'b0, 1'b0, 1'b0, 5'd2,  32'h0000_0302, 32'h1234_CDEF, 32'h0000_0000,
                     32'h0000_0300, 4'b1100, 32'hCDEF_CDEF, 32'h0000_0000, 5'd0,  1'b0};
        vecs[6]  = '{1'b0, SIZE_BYTE, 1'b0, 1'b0, 1'b0, 5'd10, 32'h0000_0002, 32'h0000_0000, 32'h00F1_0000,
                     32'h0000_0000, 4'b0100, 32'h0000_0000, 32'h0000_00F1, 5'd10, 1'b0};
        vecs[7]  = '{1'b0, SIZE_WORD, 1'b0, 1'b0, 1'b1, 5'd11, 32'h0000_0010, 32'h0000_0000, 32'h0000_FFFF,
                     32'h0000_0010, 4'b1111, 32'h0000_0000, 32'h0000_0000, 5'd11, 1'b1};
        vecs[8]  = '{1'b0, 2'b11,     1'b1, 1'b0, 1'b0, 5'd12, 32'h0000_0020, 32'h0000_0000, 32'hCAFE_F00D,
                     32'h0000_0020, 4'b1111, 32'h0000_0000, 32'hCAFE_F00D, 5'd12, 1'b0};
        vecs[9]  = '{1'b0, SIZE_BYTE, 1'b1, 1'b0, 1'b0, 5'd13, 32'h0000_0001, 32'h0000_0000, 32'h0000_7F00,
                     32'h0000_0000, 4'b0010, 32'h0000_0000, 32'h0000_007F, 5'd13, 1'b0};
        vecs[10] = '{1'b0, SIZE_WORD, 1'b0, 1'b1, 1'b0, 5'd4,  32'h0000_0102, 32'h0000_0000, 32'h0000_0000,
                     32'h0000_0100, 4'b1111, 32'h0000_0000, 32'h0000_0000, 5'd4,  1'b1};
        vecs[11] = '{1'b0, SIZE_HALF, 1'b1, 1'b1, 1'b0, 5'd6,  32'h0000_0101, 32'h0000_0000, 32'h0000_0000,
                     32'h0000_0100, 4'b0011, 32'h0000_0000, 32'h0000_0000, 5'd6,  1'b1};
        vecs[12] = '{1'b1, SIZE_WORD, 1'b0, 1'b1, 1'b0, 5'd14, 32'h0000_0203, 32'h1111_2222, 32'h0000_0000,
                     32'h0000_0200, 4'b1111, 32'h1111_2222, 32'h0000_0000, 5'd0,  1'b1};
        vecs[13] = '{1'b0, SIZE_HALF, 1'b1, 1'b0, 1'b0, 5'd15, 32'h0000_0002, 32'h0000_0000, 32'h7FFF_0000,
                     32'h0000_0000, 4'b1100, 32'h0000_0000, 32'h0000_7FFF, 5'd15, 1'b0};

        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_vec(i, vecs[i]);
        end

        // Timeout: grant given, no response for 4 WAIT cycles.
        issue(1'b0, SIZE_WORD, 1'b0, 32'h0000_0040, 32'h0000_0000, 5'd1);
        chk("to.mem_req", 32'(bus_if.mem_req_o), 32'd1);
        bus_if.mem_gnt_i = 1'b1;
        @(negedge clk);
        bus_if.mem_gnt_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("to.wait_valid", 32'(bus_if.rsp_valid_o), 32'd0);
            chk("to.wait_memreq", 32'(bus_if.mem_req_o), 32'd0);
            @(negedge clk);
        end
        chk("to.rsp_valid", 32'(bus_if.rsp_valid_o), 32'd1);
        chk("to.rsp_err",   32'(bus_if.rsp_err_o),   32'd1);
        chk("to.rsp_rdata", bus_if.rsp_rdata_o,      32'd0);
        chk("to.rsp_rd",    32'(bus_if.rsp_rd_o),    32'd1);
        finish_rsp("to");
        // Late response arriving in IDLE must be ignored.
        bus_if.mem_rvalid_i = 1'b1;
        bus_if.mem_rdata_i  = 32'h0000_0055;
        @(negedge clk);
        bus_if.mem_rvalid_i = 1'b0;
        chk("late.rsp_valid", 32'(bus_if.rsp_valid_o), 32'd0);
        chk("late.req_ready", 32'(bus_if.req_ready_o), 32'd1);
        chk("late.rsp_rdata", bus_if.rsp_rdata_o,      32'd0);
        @(negedge clk);
        chk("late.rsp_valid2", 32'(bus_if.rsp_valid_o), 32'd0);

        // Response in the same cycle the timeout would fire: response wins.
        issue(1'b0, SIZE_WORD, 1'b0, 32'h0000_0044, 32'h0000_0000, 5'd17);
        bus_if.mem_gnt_i = 1'b1;
        @(negedge clk);
        bus_if.mem_gnt_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("win.wait_valid", 32'(bus_if.rsp_valid_o), 32'd0);
            @(negedge clk);
        end
        bus_if.mem_rvalid_i = 1'b1;
        bus_if.mem_rdata_i  = 32'h0BAD_F00D;
        @(negedge clk);
        bus_if.mem_rvalid_i = 1'b0;
        chk("win.rsp_valid", 32'(bus_if.rsp_valid_o), 32'd1);
        chk("win.rsp_err",   32'(bus_if.rsp_err_o),   32'd0);
        chk("win.rsp_rdata", bus_if.rsp_rdata_o,      32'h0BAD_F00D);
        chk("win.rsp_rd",    32'(bus_if.rsp_rd_o),    32'd17);
        finish_rsp("win");

        // Reset pulsed while waiting; an in-flight response is then ignored.
        issue(1'b1, SIZE_BYTE, 1'b0, 32'h0000_0083, 32'h0000_00C3, 5'd20);
        bus_if.mem_gnt_i = 1'b1;
        @(negedge clk);
        bus_if.mem_gnt_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_wait");
        bus_if.mem_rvalid_i = 1'b1;
        bus_if.mem_rdata_i  = 32'hFFFF_FFFF;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_if.mem_rvalid_i = 1'b0;
        chk("rst_wait.rsp_valid", 32'(bus_if.rsp_valid_o), 32'd0);
        chk("rst_wait.req_ready", 32'(bus_if.req_ready_o), 32'd1);
        chk("rst_wait.mem_req",   32'(bus_if.mem_req_o),   32'd0);
        run_vec(100, vecs[4]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
